// File: rtl/mem_stage_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_sram_ctrl_if
//  Description : Pipeline-side bundle of the MEM stage. Carries the load/store
//                request from the EXE->MEM register, and the results and
//                stall status back to the pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_sram_ctrl_if;

    logic        MEM_R_EN;      // load request
    logic        MEM_W_EN;      // store request (wins over load)
    logic [31:0] ALU_Res;       // byte address, or plain ALU result
    logic [31:0] Val_Rm;        // store data
    logic [31:0] ALU_Res_Out;   // ALU_Res passed through
    logic [31:0] Mem_Data;      // last word loaded
    logic        ready;         // stage can advance; Freeze = ~ready

    // Pipeline side: issues requests, consumes results
    modport master (
        output MEM_R_EN,
        output MEM_W_EN,
        output ALU_Res,
        output Val_Rm,
        input  ALU_Res_Out,
        input  Mem_Data,
        input  ready
    );

    // MEM-stage controller side
    modport slave (
        input  MEM_R_EN,
        input  MEM_W_EN,
        input  ALU_Res,
        input  Val_Rm,
        output ALU_Res_Out,
        output Mem_Data,
        output ready
    );

endinterface : mem_stage_sram_ctrl_if
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_sram_ctrl
//  Description : MEM stage of the 5-stage pipeline. Splits each 32-bit load or
//                store into two 16-bit accesses on an external asynchronous
//                SRAM (low half first), holding ready low to freeze the
//                pipeline until the access has finished.
//  Options     : `define MEM_RANGE_CHECK_EN to skip the SRAM for addresses
//                outside [1024, 1024+2^19): such requests finish in one stall
//                cycle, loads return 0 and stores are dropped. Without it the
//                address simply wraps modulo 2^19.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage_sram_ctrl #(
    parameter int WAIT_CYCLES = 5,   // cycles per half-word access, 1..15
    parameter int SRAM_ADDR_W = 18   // SRAM half-word address width
) (
    input  wire logic                   clk,
    input  wire logic                   rst,        // asynchronous, active low
    mem_stage_sram_ctrl_if.slave        bus,
    inout  wire logic [15:0]            SRAM_DQ,
    output logic      [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                        SRAM_WE_N
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LO   = 2'd1;
    localparam logic [1:0] c_HI   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // Last value of the per-half wait counter
    localparam logic [3:0] c_LAST = 4'(WAIT_CYCLES - 1);

    // Data memory is mapped at byte 1024, i.e. word 256
    localparam logic [16:0] c_BASE_WORD = 17'd256;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        is_wr_q;          // latched operation: 1 = store
    logic [16:0] word_q;           // latched word address
    logic [31:0] data_q;           // latched store data
    logic [15:0] lo_q;             // low half captured during a load
    logic [31:0] mem_data_q;       // last loaded word

    logic        w_req;
    logic        w_in_range;
    logic [16:0] w_word;
    logic        w_cnt_last;
    logic [17:0] w_haddr;          // 18-bit half-word address before resizing
    logic        w_ready;
    logic        w_dq_oe;
    logic [15:0] w_dq_out;

    // ------------------------------------------------------------------------
    // Request decode and address translation
    // ------------------------------------------------------------------------
    assign w_req = bus.MEM_R_EN | bus.MEM_W_EN;

    // (ALU_Res - 1024)[18:2]: 1024 has no bits below bit 2, so subtracting the
    // base in word units on bits [18:2] gives the same result modulo 2^17.
    assign w_word = bus.ALU_Res[18:2] - c_BASE_WORD;

`ifdef MEM_RANGE_CHECK_EN
    assign w_in_range = (bus.ALU_Res >= 32'd1024) &&
                        (bus.ALU_Res <  32'd525312);   // 1024 + 2^19
`else
    assign w_in_range = 1'b1;
`endif

    assign w_cnt_last = (cnt_q == c_LAST);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; requests only matter in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_req) begin
                    state_d = w_in_range ? c_LO : c_DONE;
                end
            end
            c_LO: begin
                if (w_cnt_last) begin
                    state_d = c_HI;
                end
            end
            c_HI: begin
                if (w_cnt_last) begin
                    state_d = c_DONE;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state (SRAM strobes follow reset at once)
    always_comb begin
        w_ready   = 1'b0;
        w_haddr   = 18'd0;
        SRAM_WE_N = 1'b1;
        w_dq_oe   = 1'b0;
        w_dq_out  = 16'd0;
        case (state_q)
            c_IDLE: begin
                w_ready = ~w_req;
            end
            c_LO: begin
                w_haddr   = {word_q, 1'b0};
                SRAM_WE_N = ~is_wr_q;
                w_dq_oe   = is_wr_q;
                w_dq_out  = data_q[15:0];
            end
            c_HI: begin
                w_haddr   = {word_q, 1'b1};
                SRAM_WE_N = ~is_wr_q;
                w_dq_oe   = is_wr_q;
                w_dq_out  = data_q[31:16];
            end
            c_DONE: begin
                w_ready = 1'b1;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Wait counter
    // ------------------------------------------------------------------------
    // Next count: runs 0..WAIT_CYCLES-1 within each half, idle elsewhere
    always_comb begin
        cnt_d = 4'd0;
        if ((state_q == c_LO) || (state_q == c_HI)) begin
            cnt_d = w_cnt_last ? 4'd0 : (cnt_q + 4'd1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------------
    // Capture operation, address and store data when a request is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_wr_q <= 1'b0;
            word_q  <= 17'd0;
            data_q  <= 32'd0;
        end else if ((state_q == c_IDLE) && w_req) begin
            is_wr_q <= bus.MEM_W_EN;
            word_q  <= w_word;
            data_q  <= bus.Val_Rm;
        end
    end

    // ------------------------------------------------------------------------
    // Load data path
    // ------------------------------------------------------------------------
    // Sample the bus on the last wait cycle of each half; the full word is
    // published as the FSM enters DONE and held across stores.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q       <= 16'd0;
            mem_data_q <= 32'd0;
        end else begin
            if ((state_q == c_LO) && w_cnt_last && !is_wr_q) begin
                lo_q <= SRAM_DQ;
            end
            if ((state_q == c_HI) && w_cnt_last && !is_wr_q) begin
                mem_data_q <= {SRAM_DQ, lo_q};
            end
            // Rejected out-of-range load returns zero
            if ((state_q == c_IDLE) && w_req && !bus.MEM_W_EN && !w_in_range) begin
                mem_data_q <= 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Port drivers
    // ------------------------------------------------------------------------
    assign bus.ALU_Res_Out = bus.ALU_Res;
    assign bus.Mem_Data    = mem_data_q;
    assign bus.ready       = w_ready;

    // The controller only owns the data bus while a store is in progress
    assign SRAM_DQ = w_dq_oe ? w_dq_out : 16'bz;

    generate
        if (SRAM_ADDR_W == 18) begin : g_addr_exact
            assign SRAM_ADDR = w_haddr;
        end else if (SRAM_ADDR_W > 18) begin : g_addr_pad
            assign SRAM_ADDR = {{(SRAM_ADDR_W - 18){1'b0}}, w_haddr};
        end else begin : g_addr_trunc
            assign SRAM_ADDR = w_haddr[SRAM_ADDR_W-1:0];
        end
    endgenerate

endmodule : mem_stage_sram_ctrl
`default_nettype wire

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory-access stage of the 5-stage pipeline. It sits between the EXE→MEM pipeline register and the MEM→WB pipeline register. It turns a 32-bit load or store into two 16-bit accesses on the external SRAM and drives `Freeze` (as `~ready`) to stall every pipeline register until the access completes. It supplies `Mem_Data` and passes the ALU result through to the MEM→WB register.

## Interface
Parameters:
- `WAIT_CYCLES`, default 5: clock cycles spent on each 16-bit half-word access; legal range 1–15.
- `SRAM_ADDR_W`, default 18: SRAM address width.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `MEM_R_EN` input 1: load request for the instruction currently in MEM.
- `MEM_W_EN` input 1: store request.
- `ALU_Res` input 32: byte address for load/store; otherwise the ALU result.
- `Val_Rm` input 32: store data.
- `ALU_Res_Out` output 32: `ALU_Res` passed through combinationally.
- `Mem_Data` output 32: last word loaded.
- `ready` output 1: 1 when the MEM stage can advance; pipeline `Freeze = ~ready`.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` output `SRAM_ADDR_W`: SRAM half-word address.
- `SRAM_WE_N` output 1: active-low SRAM write enable.

## Operation
- Address translation:
  - `offs = ALU_Res - 1024`
  - `word = offs[18:2]`, 17 bits
  - low half address = `{word,1'b0}`, high half address = `{word,1'b1}`
  - `offs[1:0]` is ignored.
- FSM states: `IDLE`, `LO`, `HI`, `DONE`.
  - `IDLE`: if `MEM_W_EN` or `MEM_R_EN`, latch the operation, address and `Val_Rm`, then go to `LO`; otherwise stay.
  - If `MEM_W_EN` and `MEM_R_EN` are both 1, the request is treated as a write.
  - `LO`: drive the low-half address. The wait counter runs 0..`WAIT_CYCLES`-1; at the last count, clear the counter and go to `HI`.
  - `HI`: same as `LO`, using the high-half address; at the last count go to `DONE`.
  - `DONE`: one cycle, then `IDLE`.
- Write:
  - `SRAM_WE_N`=0 throughout `LO` and `HI`.
  - `SRAM_DQ` is driven with latched data `[15:0]` in `LO` and `[31:16]` in `HI`.
- Read:
  - `SRAM_WE_N`=1 and `SRAM_DQ`=Z.
  - `SRAM_DQ` is sampled on the last wait cycle of `LO` into the low half-register and of `HI` into the high half-register.
  - `Mem_Data` = {hi, lo} is updated on entry to `DONE`. It holds its value otherwise, including across writes.
- Outside a write, `SRAM_DQ` is always Z. In `IDLE` and `DONE`, `SRAM_ADDR` = 0.
- `ready` is combinational:
  - 1 in `IDLE` when no request is asserted;
  - 0 in `IDLE` with a request, and in `LO` and `HI`;
  - 1 in `DONE`.
- Request inputs are ignored outside `IDLE`. Upstream holds them stable because the pipeline is frozen.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - state `IDLE`, counter 0, `Mem_Data`=0;
  - `SRAM_WE_N`=1, `SRAM_ADDR`=0, `SRAM_DQ`=Z;
  - `ready`=1 when no request is asserted.
- Access latency, with the request seen in `IDLE` at cycle 0:
  - `ready` is 0 for cycles 0..2·`WAIT_CYCLES`;
  - `ready` is 1 in cycle 2·`WAIT_CYCLES`+1 (`DONE`);
  - `Mem_Data` is valid in that same cycle and is captured by the MEM→WB register on the following edge.
- With `WAIT_CYCLES`=1: each half-access takes one cycle, giving a total of 4 cycles including `DONE`.
- Back-to-back accesses: after `DONE` the FSM returns to `IDLE`, so the next instruction's request is seen one cycle later. No request is ever lost or double-issued.
- Reset asserted mid-access aborts the access immediately:
  - `SRAM_WE_N` returns to 1 asynchronously;
  - a partial write may leave the low half written;
  - `Mem_Data` becomes 0.

## Configuration
- `MEM_RANGE_CHECK_EN` defined:
  - a request with `ALU_Res` < 1024 or `ALU_Res` ≥ 1024+2^19 performs no SRAM access;
  - the FSM goes `IDLE`→`DONE` directly, so `ready` is 0 for exactly one cycle;
  - a read sets `Mem_Data`=0; a write is dropped.
- `MEM_RANGE_CHECK_EN` undefined: every request performs the full access, and the address is taken modulo 2^19.

## Test plan
- Reset: hold `rst`=0 with a request asserted → `SRAM_WE_N`=1, `SRAM_DQ`=Z, `Mem_Data`=0, state `IDLE`.
- Store, `WAIT_CYCLES`=5, `ALU_Res`=1028, `Val_Rm`=0xDEADBEEF:
  - `SRAM_ADDR`=2 with DQ=0xBEEF for 5 cycles, then `SRAM_ADDR`=3 with DQ=0xDEAD for 5 cycles;
  - `ready` low for 11 cycles and high in cycle 11.
- Load from the SRAM model holding 0x1234 at address 2 and 0xABCD at address 3, `ALU_Res`=1028 → `Mem_Data`=0xABCD1234 in `DONE`, with `SRAM_WE_N`=1 throughout.
- Back-to-back store then load to the same address → the load returns the stored word, and `ready` has exactly one high cycle between the two stalls.
- Assert `rst`=0 in the 3rd cycle of `HI` during a store → `SRAM_WE_N`=1 in the same cycle; after release the FSM is in `IDLE` with `ready`=1.
- With `MEM_RANGE_CHECK_EN` defined, load at `ALU_Res`=512 → no `SRAM_ADDR` activity, `ready` low for one cycle, `Mem_Data`=0.
